// File: rtl/bnn_seq_classifier_if.sv
// Classifier bench interface: the bench drives a sample and reads back the
// winning class and a completion flag.
interface bnn_seq_classifier_if #(
  parameter int FEAT_CNT  = 128,
  parameter int FEAT_BITS = 4,
  parameter int CLASS_CNT = 6
);
  localparam int PW = $clog2(CLASS_CNT);

  logic [FEAT_BITS*FEAT_CNT-1:0] features;
  logic [PW-1:0]                 prediction;
  logic                          done;

  modport master (output features, input prediction, input done);
  modport slave  (input features, output prediction, output done);
endinterface

// File: rtl/bnn_seq_classifier.sv
// One-hidden-layer binarized classifier, one neuron per clock through a single
// shared popcount per layer; rst doubles as the sample load/start strobe.
module bnn_seq_classifier #(
  parameter int FEAT_CNT   = 128,
  parameter int HIDDEN_CNT = 40,
  parameter int FEAT_BITS  = 4,
  parameter int CLASS_CNT  = 6,
  parameter logic [HIDDEN_CNT*FEAT_CNT-1:0]  W1 = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT-1:0] W2 = '0,
  parameter int THR1 = FEAT_CNT/2
) (
  input logic clk,
  input logic rst,
  bnn_seq_classifier_if.slave bus
);
  localparam int PC1W     = $clog2(FEAT_CNT+1);
  localparam int SUM_BITS = $clog2(HIDDEN_CNT+1);
  localparam int PW       = $clog2(CLASS_CNT);
  localparam int KH       = (HIDDEN_CNT > 1) ? $clog2(HIDDEN_CNT) : 1;
  localparam int KW       = (KH > PW) ? KH : PW;

  typedef enum logic [1:0] {LOAD, HID, OUT, DONE} state_t;

  state_t               state, state_nxt;
  logic [KW-1:0]        k;
  logic [FEAT_CNT-1:0]  xbin, xbin_d;
  logic [HIDDEN_CNT-1:0] h;
  logic [SUM_BITS-1:0]  best_score;
  logic [PW-1:0]        best_idx, prediction;
  logic                 done;
  logic [FEAT_CNT-1:0]  w1_row;
  logic [HIDDEN_CNT-1:0] w2_row;
  logic [PC1W-1:0]      pc1;
  logic [SUM_BITS-1:0]  score;
  logic                 hid_step, hid_last, out_last, take, h_bit;

  // Weight rows selected by k as a constant-index mux so k never indexes out of range
  always_comb begin
    w1_row = '0;
    for (int j = 0; j < HIDDEN_CNT; j++)
      if (k == KW'(j)) w1_row = W1[j*FEAT_CNT +: FEAT_CNT];
    w2_row = '0;
    for (int c = 0; c < CLASS_CNT; c++)
      if (k == KW'(c)) w2_row = W2[c*HIDDEN_CNT +: HIDDEN_CNT];
  end

  always_comb begin
    xbin_d = '0;
    for (int i = 0; i < FEAT_CNT; i++)
      xbin_d[i] = bus.features[i*FEAT_BITS + FEAT_BITS-1];
    pc1 = '0;
    for (int i = 0; i < FEAT_CNT; i++)
      pc1 = pc1 + PC1W'(xbin[i] ~^ w1_row[i]);
    score = '0;
    for (int j = 0; j < HIDDEN_CNT; j++)
      score = score + SUM_BITS'(h[j] ~^ w2_row[j]);
  end

  // LOAD also computes neuron 0, so edge 1 after release already does useful work
  assign hid_step = (state == LOAD) || (state == HID);
  assign hid_last = (k == KW'(HIDDEN_CNT-1));
  assign out_last = (k == KW'(CLASS_CNT-1));
  assign take     = (k == '0) || (score > best_score);
  assign h_bit    = (pc1 >= PC1W'(THR1));

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD, HID: state_nxt = hid_last ? OUT : HID;
      OUT:       if (out_last) state_nxt = DONE;
      DONE:      state_nxt = DONE;
      default:   state_nxt = LOAD;
    endcase
    if (rst) state_nxt = LOAD;
  end

  always_ff @(posedge clk) state <= state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      xbin       <= xbin_d;
      k          <= '0;
      h          <= '0;
      best_score <= '0;
      best_idx   <= '0;
      prediction <= '0;
      done       <= 1'b0;
    end else if (hid_step) begin
      for (int j = 0; j < HIDDEN_CNT; j++)
        if (k == KW'(j)) h[j] <= h_bit;
      k <= hid_last ? '0 : k + KW'(1);
    end else if (state == OUT) begin
      if (take) begin
        best_score <= score;
        best_idx   <= PW'(k);
      end
      if (out_last) begin
        prediction <= take ? PW'(k) : best_idx;
        done       <= 1'b1;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign bus.prediction = prediction;
  assign bus.done       = done;
endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Bench for bnn_seq_classifier: four small instances with different weights share
// clk/rst/features; expected classes are queued at start and checked at done.
module tb_bnn_seq_classifier;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] feat = '0;

  localparam logic [31:0] W1D = 32'h3CAA0FF0;
  localparam logic [11:0] W2D = 12'hC53;

  bnn_seq_classifier_if #(.FEAT_CNT(8), .FEAT_BITS(4), .CLASS_CNT(3)) if_a ();
  bnn_seq_classifier_if #(.FEAT_CNT(8), .FEAT_BITS(4), .CLASS_CNT(3)) if_b ();
  bnn_seq_classifier_if #(.FEAT_CNT(8), .FEAT_BITS(4), .CLASS_CNT(3)) if_c ();
  bnn_seq_classifier_if #(.FEAT_CNT(8), .FEAT_BITS(4), .CLASS_CNT(3)) if_d ();

  assign if_a.features = feat;
  assign if_b.features = feat;
  assign if_c.features = feat;
  assign if_d.features = feat;

  bnn_seq_classifier #(.FEAT_CNT(8), .HIDDEN_CNT(4), .FEAT_BITS(4), .CLASS_CNT(3),
    .W1(32'h0), .W2(12'h000), .THR1(4)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  bnn_seq_classifier #(.FEAT_CNT(8), .HIDDEN_CNT(4), .FEAT_BITS(4), .CLASS_CNT(3),
    .W1(32'h0), .W2(12'hF00), .THR1(4)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));
  bnn_seq_classifier #(.FEAT_CNT(8), .HIDDEN_CNT(4), .FEAT_BITS(4), .CLASS_CNT(3),
    .W1(32'h0), .W2(12'hFF0), .THR1(4)) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));
  bnn_seq_classifier #(.FEAT_CNT(8), .HIDDEN_CNT(4), .FEAT_BITS(4), .CLASS_CNT(3),
    .W1(W1D), .W2(W2D), .THR1(4)) dut_d (.clk(clk), .rst(rst), .bus(if_d.slave));

  always #5 clk = ~clk;

  logic [3:0][1:0] preds;
  logic [3:0]      dones;
  assign preds = {if_d.prediction, if_c.prediction, if_b.prediction, if_a.prediction};
  assign dones = {if_d.done, if_c.done, if_b.done, if_a.done};

  typedef struct {
    logic [31:0]     feat;
    logic [3:0][1:0] exp;   // index 0..3 = dut_a..dut_d
  } vec_t;

  vec_t            vecs[$];
  logic [3:0][1:0] sb[$];
  int              tests = 0;
  int              fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: straight evaluation of the network for one sample.
  function automatic logic [1:0] model(input logic [31:0] f, input logic [31:0] w1,
                                       input logic [11:0] w2);
    logic [7:0] xb;
    logic [3:0] h;
    int pc, best, bi;
    for (int i = 0; i < 8; i++) xb[i] = f[i*4+3];
    for (int j = 0; j < 4; j++) begin
      pc = 0;
      for (int i = 0; i < 8; i++) if (xb[i] == w1[j*8+i]) pc++;
      h[j] = (pc >= 4);
    end
    best = -1;
    bi = 0;
    for (int c = 0; c < 3; c++) begin
      pc = 0;
      for (int j = 0; j < 4; j++) if (h[j] == w2[c*4+j]) pc++;
      if (pc > best) begin
        best = pc;
        bi = c;
      end
    end
    return bi[1:0];
  endfunction

  function automatic logic [3:0][1:0] model_all(input logic [31:0] f);
    logic [3:0][1:0] e;
    e[0] = model(f, 32'h0, 12'h000);
    e[1] = model(f, 32'h0, 12'hF00);
    e[2] = model(f, 32'h0, 12'hFF0);
    e[3] = model(f, W1D, W2D);
    return e;
  endfunction

  // Load a sample with a one-cycle rst pulse; returns just after the rst edge.
  task automatic start(input logic [31:0] f, input string nm);
    feat = f;
    rst  = 1'b1;
    @(posedge clk); #1;
    rst  = 1'b0;
    chk({nm, " load done"}, {28'h0, dones}, 32'h0);
    chk({nm, " load pred"}, {24'h0, preds}, 32'h0);
  endtask

  // Count edges from release until done; outputs must stay 0 before that.
  task automatic finish_run(input string nm);
    int n;
    logic bad;
    logic [3:0][1:0] e;
    n = 0;
    bad = 1'b0;
    while (n < 20) begin
      @(posedge clk); #1;
      n++;
      if (if_a.done) break;
      if (dones != 4'h0 || preds != 8'h0) bad = 1'b1;
    end
    chk({nm, " busy outputs"}, {31'h0, bad}, 32'h0);
    chk({nm, " latency"}, n, 7);
    chk({nm, " done all"}, {28'h0, dones}, 32'hF);
    if (sb.size() == 0) begin
      chk({nm, " scoreboard empty"}, 32'h1, 32'h0);
    end else begin
      e = sb.pop_front();
      for (int d = 0; d < 4; d++)
        chk($sformatf("%s pred dut%0d", nm, d), {30'h0, preds[d]}, {30'h0, e[d]});
    end
  endtask

  initial begin
    logic bad;
    logic [31:0] r;

    // All-zero, boundary (4 and 5 set MSBs) and all-ones samples, then random ones
    vecs.push_back('{32'h0000_0000, {2'd0, 2'd1, 2'd2, 2'd0}});
    vecs.push_back('{32'h8888_0000, {2'd1, 2'd1, 2'd2, 2'd0}});
    vecs.push_back('{32'h0008_8888, {2'd0, 2'd0, 2'd0, 2'd0}});
    vecs.push_back('{32'hFFFF_FFFF, {2'd0, 2'd0, 2'd0, 2'd0}});
    for (int i = 0; i < 6; i++) begin
      r = $urandom;
      vecs.push_back('{r, model_all(r)});
    end

    // Reset held for 3 cycles
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("reset done c%0d", i), {28'h0, dones}, 32'h0);
      chk($sformatf("reset pred c%0d", i), {24'h0, preds}, 32'h0);
    end

    foreach (vecs[i]) begin
      start(vecs[i].feat, $sformatf("vec%0d", i));
      sb.push_back(vecs[i].exp);
      finish_run($sformatf("vec%0d", i));
    end

    // Hold through edge 20 while features wiggle
    start(32'h0, "hold");
    sb.push_back({2'd0, 2'd1, 2'd2, 2'd0});
    finish_run("hold");
    bad = 1'b0;
    for (int n = 8; n <= 20; n++) begin
      feat = $urandom;
      @(posedge clk); #1;
      if (preds != {2'd0, 2'd1, 2'd2, 2'd0} || dones != 4'hF) bad = 1'b1;
    end
    chk("hold to edge 20", {31'h0, bad}, 32'h0);

    // Features driven to all-ones right after release must be ignored
    start(32'h0, "isolate");
    feat = 32'hFFFF_FFFF;
    sb.push_back({2'd0, 2'd1, 2'd2, 2'd0});
    finish_run("isolate");

    // Abort at edge 3, reload a different sample on the abort edge
    start(32'hFFFF_FFFF, "abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst  = 1'b1;
    feat = 32'h8888_0000;
    @(posedge clk); #1;
    rst  = 1'b0;
    chk("abort done", {28'h0, dones}, 32'h0);
    chk("abort pred", {24'h0, preds}, 32'h0);
    sb.push_back({2'd1, 2'd1, 2'd2, 2'd0});
    finish_run("restart");

    chk("scoreboard drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
